// File: rtl/button_command_encoder_pkg.sv
// Shared definitions for the button command encoder: default type code,
// FSM state encoding and the one-hot classifier used on the stable button vector.
package btn_cmd_defs;

   localparam logic [1:0] TYPE_CODE_DEF = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HELD   = 2'd2,
      ST_REPEAT = 2'd3
   } state_e;

   // True when exactly one bit is set; callers zero-extend their vector to 32 bits.
   function automatic logic is_onehot(input logic [31:0] v);
      return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
   endfunction

endpackage

// File: rtl/btn_sync_stable.sv
// Two-flop synchroniser, previous-value register and stable-count for an N-bit vector.
// Emits changed_o whenever the synced vector moves and stable_tick_o once it has held still.
module btn_sync_stable #(
   parameter int unsigned N            = 5,
   parameter int unsigned DEBOUNCE_CNT = 5000000
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [N-1:0] din_i,
   output logic [N-1:0] stable_vec_o,
   output logic         stable_tick_o,
   output logic         changed_o
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CNT) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);

   logic [N-1:0]  sync1_q, sync2_q, prev_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          armed_q;

   assign changed_o     = (sync2_q != prev_q);
   // A change in the same cycle as the terminal count wins: the count restarts.
   assign stable_tick_o = armed_q && !changed_o && (cnt_q == CNT_LAST);
   assign stable_vec_o  = prev_q;

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         cnt_q   <= '0;
         armed_q <= 1'b0;
      end else begin
         sync1_q <= din_i;
         sync2_q <= sync1_q;
         if (changed_o) begin
            prev_q  <= sync2_q;
            cnt_q   <= '0;
            armed_q <= 1'b1;
         end else if (armed_q) begin
            if (stable_tick_o) armed_q <= 1'b0;
            else               cnt_q   <= cnt_d;
         end
      end
   end

endmodule

// File: rtl/button_command_encoder.sv
// Debounced push-button to command-word encoder with valid/ready output,
// multi-press conflict detection and optional hold-to-repeat.
module button_command_encoder
   import btn_cmd_defs::*;
#(
   parameter int unsigned NUM_BTN       = 5,
   parameter int unsigned DEBOUNCE_CNT  = 5000000,
   parameter logic [1:0]  TYPE_CODE     = TYPE_CODE_DEF,
   parameter bit          REPEAT_EN     = 1'b0,
   parameter int unsigned REPEAT_DLY    = 50000000,
   parameter int unsigned REPEAT_PERIOD = 10000000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn,
   input  logic               cmd_ready,
   output logic               cmd_valid,
   output logic [NUM_BTN+2:0] cmd_data,
   output logic               conflict,
   output logic               dropped
);

   localparam int unsigned RMAX = (REPEAT_DLY > REPEAT_PERIOD) ? REPEAT_DLY : REPEAT_PERIOD;
   localparam int unsigned RW   = $clog2(RMAX) + 1;
   localparam logic [RW-1:0] R_DLY_LAST = RW'(REPEAT_DLY - 1);
   localparam logic [RW-1:0] R_PER_LAST = RW'(REPEAT_PERIOD - 1);

   logic [NUM_BTN-1:0] stable_vec;
   logic               stable_tick, changed;
   logic               vec_onehot, rep_fire, evt;
   logic [NUM_BTN+2:0] cmd_word_d;

   state_e             state_q;
   logic [RW-1:0]      rcnt_q, rcnt_d;
   logic               cmd_valid_q, conflict_q, dropped_q;
   logic [NUM_BTN+2:0] cmd_data_q;

   btn_sync_stable #(
      .N            (NUM_BTN),
      .DEBOUNCE_CNT (DEBOUNCE_CNT)
   ) u_sync (
      .clk_i         (clk),
      .rst_i         (rst),
      .din_i         (btn),
      .stable_vec_o  (stable_vec),
      .stable_tick_o (stable_tick),
      .changed_o     (changed)
   );

   always_comb begin
      vec_onehot = is_onehot(32'(stable_vec));
      rep_fire   = REPEAT_EN && !changed &&
                   (((state_q == ST_HELD)   && (rcnt_q == R_DLY_LAST)) ||
                    ((state_q == ST_REPEAT) && (rcnt_q == R_PER_LAST)));
      evt        = (stable_tick && vec_onehot) || rep_fire;
      cmd_word_d = {1'b0, stable_vec, TYPE_CODE};
      rcnt_d     = rcnt_q;
      if (rcnt_q != '1) rcnt_d = rcnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rcnt_q      <= '0;
         cmd_valid_q <= 1'b0;
         cmd_data_q  <= '0;
         conflict_q  <= 1'b0;
         dropped_q   <= 1'b0;
      end else begin
         conflict_q <= 1'b0;
         dropped_q  <= 1'b0;

         if (changed) begin
            state_q <= ST_SETTLE;
            rcnt_q  <= '0;
         end else begin
            case (state_q)
               ST_SETTLE: if (stable_tick) begin
                  rcnt_q <= '0;
                  if (vec_onehot) begin
                     state_q <= ST_HELD;
                  end else begin
                     state_q <= ST_IDLE;
                     if (stable_vec != '0) conflict_q <= 1'b1;
                  end
               end
               ST_HELD: if (rep_fire) begin
                  rcnt_q  <= '0;
                  state_q <= ST_REPEAT;
               end else begin
                  rcnt_q <= rcnt_d;
               end
               ST_REPEAT: if (rep_fire) rcnt_q <= '0;
                          else          rcnt_q <= rcnt_d;
               default: ;
            endcase
         end

         // A new event in the accept cycle reloads the word instead of dropping it.
         if (evt) begin
            if (!cmd_valid_q || cmd_ready) begin
               cmd_valid_q <= 1'b1;
               cmd_data_q  <= cmd_word_d;
            end else begin
               dropped_q <= 1'b1;
            end
         end else if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
         end
      end
   end

   assign cmd_valid = cmd_valid_q;
   assign cmd_data  = cmd_data_q;
   assign conflict  = conflict_q;
   assign dropped   = dropped_q;

endmodule

// File: tb/tb_button_command_encoder.sv
// Scoreboard bench for button_command_encoder: one instance without repeat, one with.
module tb_button_command_encoder;

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] btn0, btn1;
   logic       rdy0, rdy1;
   logic       v0, c0, dr0, v1, c1, dr1;
   logic [7:0] d0, d1;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int conf0    = 0;
   int drop0    = 0;
   int conf1    = 0;
   exp_t q0[$];
   exp_t q1[$];

   button_command_encoder #(
      .NUM_BTN(5), .DEBOUNCE_CNT(4), .TYPE_CODE(2'b10),
      .REPEAT_EN(1'b0), .REPEAT_DLY(6), .REPEAT_PERIOD(3)
   ) dut (
      .clk(clk), .rst(rst), .btn(btn0), .cmd_ready(rdy0),
      .cmd_valid(v0), .cmd_data(d0), .conflict(c0), .dropped(dr0)
   );

   button_command_encoder #(
      .NUM_BTN(5), .DEBOUNCE_CNT(4), .TYPE_CODE(2'b10),
      .REPEAT_EN(1'b1), .REPEAT_DLY(6), .REPEAT_PERIOD(3)
   ) dut_rep (
      .clk(clk), .rst(rst), .btn(btn1), .cmd_ready(rdy1),
      .cmd_valid(v1), .cmd_data(d1), .conflict(c1), .dropped(dr1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (c0)  conf0++;
         if (dr0) drop0++;
         if (c1)  conf1++;
         if (v0 && rdy0) begin
            check_eq("cmd0_expected", 32'(q0.size() != 0), 32'd1);
            if (q0.size() != 0) begin
               e = q0.pop_front();
               check_eq("cmd0_data", 32'(d0), 32'(e.data));
               if (e.cyc >= 0) check_eq("cmd0_cycle", cyc, e.cyc);
            end
         end
         if (v1 && rdy1) begin
            check_eq("cmd1_expected", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) begin
               e = q1.pop_front();
               check_eq("cmd1_data", 32'(d1), 32'(e.data));
               if (e.cyc >= 0) check_eq("cmd1_cycle", cyc, e.cyc);
            end
         end
      end
   end

   initial begin
      int k, cb, db;
      rst  = 1'b1;
      btn0 = '0;
      btn1 = '0;
      rdy0 = 1'b1;
      rdy1 = 1'b1;
      step(3);
      check_eq("rst_valid", 32'(v0), 32'd0);
      check_eq("rst_data", 32'(d0), 32'd0);
      check_eq("rst_conflict", 32'(c0), 32'd0);
      check_eq("rst_dropped", 32'(dr0), 32'd0);
      rst = 1'b0;
      step(3);

      // single one-hot press, no repeat
      cb = conf0;
      k = cyc;
      btn0 = 5'b00010;
      q0.push_back('{data: 8'b0_00010_10, cyc: k + 7});
      step(20);
      btn0 = '0;
      step(12);
      check_eq("t1_pending", 32'(q0.size()), 32'd0);
      check_eq("t1_conflict", 32'(conf0 - cb), 32'd0);

      // bouncing input never settles, then a clean press
      for (int i = 0; i < 10; i++) begin
         btn0 = (i % 2 == 0) ? 5'b00001 : 5'b00000;
         step(2);
      end
      k = cyc;
      btn0 = 5'b10000;
      q0.push_back('{data: 8'b0_10000_10, cyc: k + 7});
      step(15);
      btn0 = '0;
      step(12);
      check_eq("t2_pending", 32'(q0.size()), 32'd0);

      // multi-press conflict
      cb = conf0;
      btn0 = 5'b00101;
      step(15);
      check_eq("t3_conflict", 32'(conf0 - cb), 32'd1);
      check_eq("t3_valid", 32'(v0), 32'd0);
      btn0 = '0;
      step(12);

      // backpressure: second command dropped, first kept
      rdy0 = 1'b0;
      db = drop0;
      btn0 = 5'b00001;
      q0.push_back('{data: 8'b0_00001_10, cyc: -1});
      step(12);
      check_eq("t4_valid", 32'(v0), 32'd1);
      check_eq("t4_data", 32'(d0), 32'h0000_0006);
      btn0 = '0;
      step(12);
      btn0 = 5'b00100;
      step(12);
      check_eq("t4_dropped", 32'(drop0 - db), 32'd1);
      check_eq("t4_held", 32'(d0), 32'h0000_0006);
      btn0 = '0;
      step(12);
      rdy0 = 1'b1;
      step(4);
      check_eq("t4_pending", 32'(q0.size()), 32'd0);
      check_eq("t4_cleared", 32'(v0), 32'd0);

      // hold-to-repeat
      k = cyc;
      btn1 = 5'b01000;
      q1.push_back('{data: 8'b0_01000_10, cyc: k + 7});
      q1.push_back('{data: 8'b0_01000_10, cyc: k + 13});
      q1.push_back('{data: 8'b0_01000_10, cyc: k + 16});
      q1.push_back('{data: 8'b0_01000_10, cyc: k + 19});
      step(17);
      btn1 = '0;
      step(25);
      check_eq("t5_pending", 32'(q1.size()), 32'd0);
      check_eq("t5_conflict", 32'(conf1), 32'd0);

      // reset mid-settle
      btn0 = 5'b00010;
      step(4);
      rst  = 1'b1;
      btn0 = '0;
      #1;
      check_eq("t6a_valid", 32'(v0), 32'd0);
      check_eq("t6a_data", 32'(d0), 32'd0);
      step(2);
      rst = 1'b0;
      step(15);

      // reset while a command is pending
      rdy0 = 1'b0;
      btn0 = 5'b00010;
      q0.push_back('{data: 8'b0_00010_10, cyc: -1});
      step(9);
      check_eq("t6b_valid_pre", 32'(v0), 32'd1);
      rst  = 1'b1;
      btn0 = '0;
      #1;
      check_eq("t6b_valid", 32'(v0), 32'd0);
      check_eq("t6b_data", 32'(d0), 32'd0);
      check_eq("t6b_conflict", 32'(c0), 32'd0);
      check_eq("t6b_dropped", 32'(dr0), 32'd0);
      q0.delete();
      step(2);
      rst  = 1'b0;
      rdy0 = 1'b1;
      step(15);
      check_eq("t6b_quiet", 32'(v0), 32'd0);
      k = cyc;
      btn0 = 5'b00100;
      q0.push_back('{data: 8'b0_00100_10, cyc: k + 7});
      step(12);
      btn0 = '0;
      step(12);
      check_eq("t6_pending", 32'(q0.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
